// File: rtl/seq_multiplier_if.sv
// Request/response bundle for the sequential multiplier.
// The master drives the operands and start; the slave reports busy/done and HI/LO.
// Latency and backpressure are properties of the slave and are described there.
interface seq_multiplier_if #(
  parameter int WIDTH = 32
);
  logic             i_start;
  logic             i_is_signed;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             o_busy;
  logic             o_done;
  logic [WIDTH-1:0] o_hi;
  logic [WIDTH-1:0] o_lo;

  modport master (
    output i_start, i_is_signed, i_a, i_b,
    input  o_busy, o_done, o_hi, o_lo
  );

  modport slave (
    input  i_start, i_is_signed, i_a, i_b,
    output o_busy, o_done, o_hi, o_lo
  );
endinterface

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier producing a 64-bit HI/LO product, signed or unsigned.
// Latency: start sampled at E0 -> HI/LO written and done raised at E33 (one-cycle pulse).
// Backpressure: none; start is only accepted in IDLE and is silently dropped while busy/done.
module seq_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic            clk,
  input  logic            rst,
  seq_multiplier_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FIXUP = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_busy;
  logic               w_done;

  logic [WIDTH-1:0]   r_mcand;   // multiplicand magnitude
  logic [2*WIDTH-1:0] r_acc;     // {partial product high, partial low / remaining multiplier}
  logic [CW-1:0]      r_cnt;
  logic               r_neg;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH-1:0]   w_addend;
  logic [WIDTH-1:0]   w_sum;
  logic [WIDTH:0]     w_carry;

  // Magnitudes of the live operands; 0x80000000 negates to itself, which is 2^31 unsigned.
  assign w_mag_a = (bus.i_is_signed && bus.i_a[WIDTH-1]) ? (~bus.i_a + 1'b1) : bus.i_a;
  assign w_mag_b = (bus.i_is_signed && bus.i_b[WIDTH-1]) ? (~bus.i_b + 1'b1) : bus.i_b;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and status decode.
  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE:  if (bus.i_start) w_state_nxt = S_RUN;
      S_RUN: begin
        w_busy = 1'b1;
        if (r_cnt == CW'(WIDTH - 1)) w_state_nxt = S_FIXUP;
      end
      S_FIXUP: begin
        w_busy      = 1'b1;
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Ripple-carry add of the multiplicand (gated by multiplier LSB) into the upper half, Cin = 0.
  always_comb begin
    w_addend   = r_acc[0] ? r_mcand : '0;
    w_sum      = '0;
    w_carry    = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_sum[i]       = r_acc[WIDTH+i] ^ w_addend[i] ^ w_carry[i];
      w_carry[i+1]   = (r_acc[WIDTH+i] & w_addend[i]) |
                       (w_carry[i] & (r_acc[WIDTH+i] ^ w_addend[i]));
    end
  end

  // Operand latch, shift-add iterations and final sign correction into HI/LO.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcand <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_neg   <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.i_start) begin
            r_mcand <= w_mag_a;
            r_acc   <= {{WIDTH{1'b0}}, w_mag_b};
            r_cnt   <= '0;
            r_neg   <= bus.i_is_signed & (bus.i_a[WIDTH-1] ^ bus.i_b[WIDTH-1]);
          end
        end
        S_RUN: begin
          // Carry-out lands in bit 63; the consumed multiplier bit falls off bit 0.
          r_acc <= {w_carry[WIDTH], w_sum, r_acc[WIDTH-1:1]};
          r_cnt <= r_cnt + 1'b1;
        end
        S_FIXUP: begin
          {r_hi, r_lo} <= r_neg ? (~r_acc + 1'b1) : r_acc;
        end
        default: ;
      endcase
    end
  end

  assign bus.o_busy = w_busy;
  assign bus.o_done = w_done;
  assign bus.o_hi   = r_hi;
  assign bus.o_lo   = r_lo;
endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier: products, latency, ignored starts and mid-run reset.
module tb_seq_multiplier;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  seq_multiplier_if #(.WIDTH(32)) bus ();

  seq_multiplier #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] prev_hi;
  logic [31:0] prev_lo;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present operands with start for one edge (E0), then scramble the inputs.
  task automatic go(input logic [31:0] a, input logic [31:0] b, input logic s);
    bus.i_a         = a;
    bus.i_b         = b;
    bus.i_is_signed = s;
    bus.i_start     = 1'b1;
    tick();
    bus.i_start     = 1'b0;
    bus.i_a         = ~a;
    bus.i_b         = b ^ 32'h5A5A_0F0F;
    bus.i_is_signed = ~s;
  endtask

  task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input logic s, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int lat;
    lat = -1;
    go(a, b, s);
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (k == 1)  check({tag, " busy_e1"}, 64'(bus.o_busy), 64'd1);
      if (k == 16) check({tag, " hold"}, {bus.o_hi, bus.o_lo}, {prev_hi, prev_lo});
      if (k == 32) check({tag, " busy_e32"}, 64'(bus.o_busy), 64'd1);
      if (bus.o_done) begin
        lat = k;
        break;
      end
    end
    check({tag, " latency"}, 64'(lat), 64'd33);
    check({tag, " busy_at_done"}, 64'(bus.o_busy), 64'd0);
    check({tag, " result"}, {bus.o_hi, bus.o_lo}, {exp_hi, exp_lo});
    tick();
    check({tag, " done_pulse"}, 64'(bus.o_done), 64'd0);
    prev_hi = exp_hi;
    prev_lo = exp_lo;
  endtask

  initial begin
    int lat;
    int n_done;
    int n_busy;

    // Reset with start held high: reset wins.
    rst             = 1'b1;
    bus.i_start     = 1'b1;
    bus.i_is_signed = 1'b0;
    bus.i_a         = 32'd3;
    bus.i_b         = 32'd5;
    tick();
    tick();
    check("rst busy", 64'(bus.o_busy), 64'd0);
    check("rst done", 64'(bus.o_done), 64'd0);
    check("rst hilo", {bus.o_hi, bus.o_lo}, 64'd0);
    rst         = 1'b0;
    bus.i_start = 1'b0;
    tick();
    check("post_rst idle", 64'(bus.o_busy), 64'd0);
    prev_hi = 32'h0;
    prev_lo = 32'h0;

    run("u_3x5",     32'd3,         32'd5,         1'b0, 32'h0000_0000, 32'h0000_000F);
    run("u_max",     32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001);
    run("s_m1x1",    32'hFFFF_FFFF, 32'd1,         1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run("u_m1x1",    32'hFFFF_FFFF, 32'd1,         1'b0, 32'h0000_0000, 32'hFFFF_FFFF);
    run("s_minxmin", 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h4000_0000, 32'h0000_0000);
    run("s_minx1",   32'h8000_0000, 32'd1,         1'b1, 32'hFFFF_FFFF, 32'h8000_0000);

    // Start pulsed at E10 while busy, and again in DONE: both must be ignored.
    lat = -1;
    go(32'd2, 32'd3, 1'b0);
    for (int k = 1; k <= 40; k++) begin
      if (k == 10) begin
        bus.i_start     = 1'b1;
        bus.i_a         = 32'd7;
        bus.i_b         = 32'd7;
        bus.i_is_signed = 1'b1;
      end
      tick();
      if (k == 10) bus.i_start = 1'b0;
      if (bus.o_done) begin
        lat = k;
        break;
      end
    end
    check("busy_start latency", 64'(lat), 64'd33);
    check("busy_start result", {bus.o_hi, bus.o_lo}, 64'd6);
    bus.i_start = 1'b1;
    bus.i_a     = 32'd9;
    bus.i_b     = 32'd9;
    tick();
    bus.i_start = 1'b0;
    check("done_start done", 64'(bus.o_done), 64'd0);
    check("done_start busy", 64'(bus.o_busy), 64'd0);
    n_done = 0;
    n_busy = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (bus.o_done) n_done++;
      if (bus.o_busy) n_busy++;
    end
    check("ignored_start extra_done", 64'(n_done), 64'd0);
    check("ignored_start extra_busy", 64'(n_busy), 64'd0);
    check("ignored_start hold", {bus.o_hi, bus.o_lo}, 64'd6);
    prev_hi = 32'h0;
    prev_lo = 32'd6;

    // Reset in the middle of a 4*4 run.
    run("r_3x5", 32'd3, 32'd5, 1'b0, 32'h0, 32'd15);
    go(32'd4, 32'd4, 1'b0);
    for (int k = 1; k <= 15; k++) tick();
    check("midrun busy", 64'(bus.o_busy), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst busy", 64'(bus.o_busy), 64'd0);
    check("midrst done", 64'(bus.o_done), 64'd0);
    check("midrst hilo", {bus.o_hi, bus.o_lo}, 64'd0);
    n_done = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (bus.o_done) n_done++;
    end
    check("midrst no_done", 64'(n_done), 64'd0);
    check("midrst hold", {bus.o_hi, bus.o_lo}, 64'd0);
    prev_hi = 32'h0;
    prev_lo = 32'h0;
    run("post_midrst 6x7", 32'd6, 32'd7, 1'b0, 32'h0, 32'd42);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width; only 32 is required to be supported.
REQ-002 SHALL have clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have start  input  1  request to begin a multiply; sampled only in IDLE.
REQ-005 SHALL have is_signed  input  1  1 = two's-complement multiply (MULT); 0 = unsigned (MULTU); sampled with start.
REQ-006 SHALL have a  input  32  multiplicand; sampled with start.
REQ-007 SHALL have b  input  32  multiplier; sampled with start.
REQ-008 SHALL have busy  output  1  high while an operation is in progress (RUN or FIXUP).
REQ-009 SHALL have done  output  1  one-cycle pulse marking the result as just written.
REQ-010 SHALL have hi  output  32  upper half of the 64-bit product (HI register).
REQ-011 SHALL have lo  output  32  lower half of the 64-bit product (LO register).

Function
REQ-012 SHALL implement FSM states IDLE, RUN, FIXUP, DONE.
REQ-013 In IDLE with start=1 at an edge, SHALL latch a, b, is_signed, clear the accumulator and iteration counter, and enter RUN; start=0 stays IDLE.
REQ-014 At latch, SHALL convert operands to unsigned magnitudes: if is_signed and the operand MSB is 1, use its two's complement; 0x80000000 yields magnitude 2^31, which fits 32 bits unsigned.
REQ-015 SHALL record neg = is_signed & (a[31] ^ b[31]) at latch.
REQ-016 Each RUN cycle: if the multiplier LSB is 1, SHALL add the multiplicand magnitude to the upper 32 accumulator bits through a 32-bit ripple adder, with Cin=0 and 33-bit result including carry-out; otherwise add 0.
REQ-017 Each RUN cycle: SHALL shift {carry, acc_hi, acc_lo/multiplier} right by one bit, so the carry enters bit 63 and the multiplier LSB is consumed.
REQ-018 SHALL remain in RUN for exactly 32 cycles, counted by a 5-bit counter that wraps 31->0 on the final iteration, then enter FIXUP.
REQ-019 In FIXUP, SHALL write {hi,lo} = neg ? (~P + 1) mod 2^64 : P, where P is the 64-bit magnitude product, then enter DONE.
REQ-020 In DONE, SHALL assert done for exactly one cycle, then return to IDLE; start seen in DONE is ignored.
REQ-021 Latency: with start sampled at edge E0, SHALL update hi/lo at edge E33 and drive done high from E33 to E34; busy SHALL be high from E1 to E33.
REQ-022 start asserted while busy or in DONE SHALL be ignored, with no effect on the latched operands or the result.
REQ-023 Changes on a, b or is_signed after the start edge SHALL NOT affect the in-flight operation.
REQ-024 hi/lo SHALL hold the previous result through IDLE, RUN and DONE and change only in FIXUP or on reset.
REQ-025 busy and done SHALL never be high in the same cycle.

Reset
REQ-026 rst=1 at an edge SHALL force the IDLE state, busy=0, done=0, hi=0, lo=0, and clear the counter and accumulator, whatever state the block is in.
REQ-027 rst SHALL take priority over start in the same cycle.
REQ-028 rst mid-RUN SHALL abandon the operation without writing any partial product to hi/lo.

Verification
REQ-029 Unsigned: a=3, b=5, is_signed=0 -> hi=0x00000000, lo=0x0000000F, done high exactly 33 edges after start.
REQ-030 Unsigned max: a=b=0xFFFFFFFF, is_signed=0 -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-031 Signed: a=0xFFFFFFFF (-1), b=1, is_signed=1 -> hi=0xFFFFFFFF, lo=0xFFFFFFFF; same operands with is_signed=0 -> hi=0x00000000, lo=0xFFFFFFFF.
REQ-032 Signed corner: a=b=0x80000000, is_signed=1 -> hi=0x40000000, lo=0x00000000; a=0x80000000, b=1 -> hi=0xFFFFFFFF, lo=0x80000000.
REQ-033 Start while busy: start a=2, b=3; pulse start with a=7, b=7 at E10 -> result 6, single done pulse, and no second operation starts.
REQ-034 Reset mid-op: complete 3*5; start 4*4; assert rst at E16 -> hi=0, lo=0, busy=0, no done; a new start then completes normally.
